// File: rtl/fir_lane_serializer.sv
// rtl/fir_lane_serializer.sv - round/shift/saturate three FIR lane accumulators and serialize them.
// Whole triples are buffered in a small FIFO and emitted lane 0, 1, 2 over valid/ready.
module fir_lane_serializer #(
  parameter int IN_W  = 48,
  parameter int OUT_W = 24,
  parameter int SHIFT = 23,
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [IN_W-1:0]   in_lane0,
  input  logic [IN_W-1:0]   in_lane1,
  input  logic [IN_W-1:0]   in_lane2,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OUT_W-1:0]  out_data,
  output logic [1:0]        out_phase,
  output logic              sat_flag,
  output logic [15:0]       sat_count,
  input  logic              sat_clear
);

  localparam int AW     = $clog2(DEPTH);
  localparam int RND_SH = (SHIFT > 0) ? SHIFT - 1 : 0;
  localparam logic [IN_W:0] ONE = {{IN_W{1'b0}}, 1'b1};
  localparam logic [IN_W:0] RND = (SHIFT > 0) ? (ONE << RND_SH) : '0;
  localparam logic signed [IN_W:0] MAXV = {{(IN_W-OUT_W+2){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [IN_W:0] MINV = {{(IN_W-OUT_W+2){1'b1}}, {(OUT_W-1){1'b0}}};

  // Returns {clipped, value}; the extra bit keeps the rounding add from overflowing.
  function automatic logic [OUT_W:0] convert(input logic [IN_W-1:0] x);
    logic signed [IN_W:0] t;
    t = ($signed({x[IN_W-1], x}) + $signed(RND)) >>> SHIFT;
    if (t > MAXV)
      return {1'b1, MAXV[OUT_W-1:0]};
    else if (t < MINV)
      return {1'b1, MINV[OUT_W-1:0]};
    else
      return {1'b0, t[OUT_W-1:0]};
  endfunction

  logic [OUT_W-1:0] mem0 [DEPTH];
  logic [OUT_W-1:0] mem1 [DEPTH];
  logic [OUT_W-1:0] mem2 [DEPTH];

  logic [AW:0]      count;
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic [OUT_W:0]   c0, c1, c2;
  logic [1:0]       nclip;
  logic [16:0]      sat_sum;
  logic             push;
  logic             xfer;
  logic             pop;

  assign in_ready  = (count < (AW+1)'(DEPTH));
  assign out_valid = (count != '0);
  assign push      = in_valid && in_ready;
  assign xfer      = out_valid && out_ready;
  assign pop       = xfer && (out_phase == 2'd2);

  always_comb begin
    c0      = convert(in_lane0);
    c1      = convert(in_lane1);
    c2      = convert(in_lane2);
    nclip   = {1'b0, c0[OUT_W]} + {1'b0, c1[OUT_W]} + {1'b0, c2[OUT_W]};
    sat_sum = {1'b0, sat_count} + {15'd0, nclip};
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem0[wptr] <= c0[OUT_W-1:0];
      mem1[wptr] <= c1[OUT_W-1:0];
      mem2[wptr] <= c2[OUT_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count     <= '0;
      wptr      <= '0;
      rptr      <= '0;
      out_phase <= 2'd0;
    end else begin
      if (push)
        wptr <= wptr + AW'(1);
      if (pop)
        rptr <= rptr + AW'(1);
      if (xfer)
        out_phase <= (out_phase == 2'd2) ? 2'd0 : out_phase + 2'd1;
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Clear beats a clip landing in the same cycle.
  always_ff @(posedge clk) begin
    if (reset || sat_clear) begin
      sat_flag  <= 1'b0;
      sat_count <= 16'd0;
    end else if (push && (nclip != 2'd0)) begin
      sat_flag  <= 1'b1;
      sat_count <= sat_sum[16] ? 16'hFFFF : sat_sum[15:0];
    end
  end

  always_comb begin
    out_data = '0;
    if (out_valid) begin
      case (out_phase)
        2'd0:    out_data = mem0[rptr];
        2'd1:    out_data = mem1[rptr];
        default: out_data = mem2[rptr];
      endcase
    end
  end

endmodule

// File: tb/tb_fir_lane_serializer.sv
// tb/tb_fir_lane_serializer.sv - self-checking bench for fir_lane_serializer against a triple-queue model.
module tb_fir_lane_serializer;

  logic               clk = 1'b0;
  logic               reset;
  logic               in_valid;
  logic               in_ready;
  logic signed [47:0] in_lane0, in_lane1, in_lane2;
  logic               out_valid;
  logic               out_ready;
  logic signed [23:0] out_data;
  logic [1:0]         out_phase;
  logic               sat_flag;
  logic [15:0]        sat_count;
  logic               sat_clear;

  fir_lane_serializer #(.IN_W(48), .OUT_W(24), .SHIFT(23), .DEPTH(4)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_lane0(in_lane0), .in_lane1(in_lane1), .in_lane2(in_lane2),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_phase(out_phase), .sat_flag(sat_flag), .sat_count(sat_count),
    .sat_clear(sat_clear)
  );

  always #5 clk = ~clk;

  typedef struct { int d[3]; } trip_t;
  trip_t tq[$];
  int    mph;
  int    msat;
  bit    mflag;
  int    nassert = 0;
  int    nfail   = 0;
  bit    acc;

  task automatic chk(string tag, logic signed [63:0] got, logic signed [63:0] exp);
    nassert++;
    assert (got === exp) else begin
      nfail++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Round half up by 2^23 with floor semantics, then clip to 24-bit signed.
  function automatic int conv(longint x, inout int clips);
    longint t;
    t = (x + 64'sd4194304) >>> 23;
    if (t > 64'sd8388607) begin clips++; return 8388607; end
    if (t < -64'sd8388608) begin clips++; return -8388608; end
    return int'(t);
  endfunction

  function automatic logic signed [47:0] rnd_lane();
    logic [63:0] w;
    int sel;
    w   = {$urandom(), $urandom()};
    sel = $urandom_range(9, 0);
    if (sel == 0) return 48'sh7FFF_FFFF_FFFF;
    if (sel == 1) return 48'sh8000_0000_0000;
    return $signed(w[47:0]) >>> $urandom_range(24, 0);
  endfunction

  task automatic cycle(output bit accepted);
    bit push, xfer;
    int clips;
    trip_t tr;
    @(negedge clk);
    chk("out_valid", out_valid, tq.size() != 0);
    chk("in_ready",  in_ready,  tq.size() < 4);
    chk("out_phase", out_phase, (tq.size() != 0) ? mph : 0);
    chk("out_data",  out_data,  (tq.size() != 0) ? tq[0].d[mph] : 0);
    chk("sat_flag",  sat_flag,  mflag);
    chk("sat_count", sat_count, msat);
    push = !reset && in_valid && (tq.size() < 4);
    xfer = !reset && out_ready && (tq.size() != 0);
    clips = 0;
    if (push) begin
      tr.d[0] = conv(longint'(in_lane0), clips);
      tr.d[1] = conv(longint'(in_lane1), clips);
      tr.d[2] = conv(longint'(in_lane2), clips);
    end
    @(posedge clk);
    if (reset) begin
      tq.delete(); mph = 0; msat = 0; mflag = 0;
    end else begin
      if (xfer) begin
        mph++;
        if (mph == 3) begin mph = 0; void'(tq.pop_front()); end
      end
      if (push) tq.push_back(tr);
      if (sat_clear) begin
        msat = 0; mflag = 0;
      end else if (clips != 0) begin
        mflag = 1;
        msat = (msat + clips > 65535) ? 65535 : msat + clips;
      end
    end
    accepted = push;
    #1;
  endtask

  task automatic set_lanes(logic signed [47:0] a, logic signed [47:0] b, logic signed [47:0] c);
    in_lane0 = a; in_lane1 = b; in_lane2 = c;
  endtask

  // Holds a triple until accepted; optionally raises out_ready after some cycles.
  task automatic send(logic signed [47:0] a, logic signed [47:0] b, logic signed [47:0] c,
                      int release_after);
    bit got;
    got = 0;
    set_lanes(a, b, c);
    in_valid = 1;
    for (int n = 0; n < 40 && !got; n++) begin
      if (n == release_after) out_ready = 1;
      cycle(got);
    end
    in_valid = 0;
    chk("send_accepted", got, 1);
  endtask

  initial begin
    mph = 0; msat = 0; mflag = 0;
    reset = 1; in_valid = 0; out_ready = 0; sat_clear = 0;
    set_lanes(0, 0, 0);
    repeat (2) cycle(acc);
    reset = 0;
    cycle(acc);

    // Rounding: 1.0, 1.5 and -1.5 in Q23
    out_ready = 1;
    send(48'sd8388608, 48'sd12582912, -48'sd12582912, -1);
    repeat (4) cycle(acc);

    // Clipping both rails, then clear
    send(48'sh7FFF_FFFF_FFFF, 48'sh8000_0000_0000, 48'sd0, -1);
    repeat (4) cycle(acc);
    chk("sat_count_two", sat_count, 2);
    sat_clear = 1; cycle(acc); sat_clear = 0;
    cycle(acc);

    // Stalled consumer: four fill, fifth waits for out_ready
    out_ready = 0;
    for (int i = 0; i < 5; i++)
      send(rnd_lane(), rnd_lane(), rnd_lane(), (i == 4) ? 6 : -1);
    repeat (16) cycle(acc);

    // Full FIFO with continuous input: the pop cycle refuses the push
    out_ready = 0;
    for (int i = 0; i < 4; i++) send(rnd_lane(), rnd_lane(), rnd_lane(), -1);
    out_ready = 1; in_valid = 1;
    for (int i = 0; i < 12; i++) begin
      cycle(acc);
      if (acc) set_lanes(rnd_lane(), rnd_lane(), rnd_lane());
    end
    in_valid = 0;
    repeat (16) cycle(acc);

    // Toggling out_ready
    out_ready = 1;
    send(rnd_lane(), rnd_lane(), rnd_lane(), -1);
    for (int i = 0; i < 10; i++) begin out_ready = ~out_ready; cycle(acc); end

    // Reset with three triples buffered at phase 1
    out_ready = 0;
    for (int i = 0; i < 3; i++) send(rnd_lane(), rnd_lane(), rnd_lane(), -1);
    out_ready = 1; cycle(acc);
    out_ready = 0; cycle(acc);
    reset = 1; cycle(acc); reset = 0;
    cycle(acc);
    out_ready = 1;
    send(48'sd16777216, -48'sd8388608, 48'sd4194304, -1);
    repeat (4) cycle(acc);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(3, 0) != 0);
      out_ready = ($urandom_range(3, 0) != 0);
      sat_clear = ($urandom_range(31, 0) == 0);
      set_lanes(rnd_lane(), rnd_lane(), rnd_lane());
      cycle(acc);
    end
    in_valid = 0; sat_clear = 0; out_ready = 1;
    repeat (16) cycle(acc);
    chk("drained", tq.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", nassert, nfail);
    $finish;
  end

endmodule
